// File: rtl/ecc_apb_sequencer_if.sv
// Bundle of command, APB, ECC-completion and response signals for ecc_apb_sequencer.
// The sequencer connects through the master modport; its environment uses slave.
interface ecc_apb_sequencer_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_op;
    logic [1:0]                 cmd_width;
    logic [AMBA_WORD-1:0]       cmd_data;
    logic [AMBA_WORD-1:0]       cmd_noise;

    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;

    logic                       operation_done;
    logic [DATA_WIDTH-1:0]      data_out;
    logic [1:0]                 num_of_errors;

    logic                       rsp_valid;
    logic [DATA_WIDTH-1:0]      rsp_data;
    logic [1:0]                 rsp_errors;
    logic [1:0]                 rsp_status;
    logic                       busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_width, cmd_data, cmd_noise,
        input  operation_done, data_out, num_of_errors,
        output cmd_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        output rsp_valid, rsp_data, rsp_errors, rsp_status, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_width, cmd_data, cmd_noise,
        output operation_done, data_out, num_of_errors,
        input  cmd_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        input  rsp_valid, rsp_data, rsp_errors, rsp_status, busy
    );
endinterface

// File: rtl/ecc_apb_sequencer.sv
// Turns one ECC command into four APB register writes, waits for the ECC block to
// finish (with timeout) and returns a single-cycle response. All outputs registered.
module ecc_apb_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    ecc_apb_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] STATUS_OK      = 2'd0;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd1;
    localparam logic [1:0] STATUS_ILLEGAL = 2'd2;

    state_t                     state_r;
    logic [1:0]                 idx_r;
    logic [CNT_W-1:0]           cnt_r;
    logic [1:0]                 op_r;
    logic [1:0]                 width_r;
    logic [AMBA_WORD-1:0]       data_r;
    logic [AMBA_WORD-1:0]       noise_r;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_r;
    logic [AMBA_WORD-1:0]       pwdata_r;
    logic                       psel_r;
    logic                       penable_r;
    logic                       pwrite_r;
    logic                       rsp_valid_r;
    logic [DATA_WIDTH-1:0]      rsp_data_r;
    logic [1:0]                 rsp_errors_r;
    logic [1:0]                 rsp_status_r;
    logic                       busy_r;
    logic                       cmd_ready_r;

    logic [1:0]                 next_idx_s;
    logic                       accept_s;
    logic                       illegal_s;

    // Write order: CODEWORD_WIDTH, DATA_IN, NOISE, then CTRL which starts the ECC block.
    function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    reg_addr = AMBA_ADDR_WIDTH'(8'h08);
            2'd1:    reg_addr = AMBA_ADDR_WIDTH'(8'h04);
            2'd2:    reg_addr = AMBA_ADDR_WIDTH'(8'h0C);
            default: reg_addr = AMBA_ADDR_WIDTH'(8'h00);
        endcase
    endfunction

    function automatic logic [AMBA_WORD-1:0] reg_data(
        input logic [1:0]           idx,
        input logic [1:0]           op,
        input logic [1:0]           width,
        input logic [AMBA_WORD-1:0] data,
        input logic [AMBA_WORD-1:0] noise
    );
        case (idx)
            2'd0:    reg_data = AMBA_WORD'(width);
            2'd1:    reg_data = data;
            2'd2:    reg_data = noise;
            default: reg_data = AMBA_WORD'(op);
        endcase
    endfunction

    // Handshake decode and next write index.
    always_comb begin
        next_idx_s = idx_r + 2'd1;
        accept_s   = bus.cmd_valid && cmd_ready_r;
        illegal_s  = (bus.cmd_op == 2'd3) || (bus.cmd_width == 2'd3);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 2'd0;
            cnt_r        <= '0;
            op_r         <= 2'd0;
            width_r      <= 2'd0;
            data_r       <= '0;
            noise_r      <= '0;
            paddr_r      <= '0;
            pwdata_r     <= '0;
            psel_r       <= 1'b0;
            penable_r    <= 1'b0;
            pwrite_r     <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= '0;
            rsp_errors_r <= 2'd0;
            rsp_status_r <= 2'd0;
            busy_r       <= 1'b0;
            cmd_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r        <= bus.cmd_op;
                        width_r     <= bus.cmd_width;
                        data_r      <= bus.cmd_data;
                        noise_r     <= bus.cmd_noise;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        idx_r       <= 2'd0;
                        if (illegal_s) begin
                            state_r      <= ST_RESP;
                            rsp_valid_r  <= 1'b1;
                            rsp_status_r <= STATUS_ILLEGAL;
                            rsp_data_r   <= '0;
                            rsp_errors_r <= 2'd0;
                        end else begin
                            state_r   <= ST_SETUP;
                            psel_r    <= 1'b1;
                            penable_r <= 1'b0;
                            pwrite_r  <= 1'b1;
                            paddr_r   <= reg_addr(2'd0);
                            pwdata_r  <= reg_data(2'd0, bus.cmd_op, bus.cmd_width,
                                                  bus.cmd_data, bus.cmd_noise);
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    penable_r <= 1'b0;
                    if (idx_r != 2'd3) begin
                        idx_r    <= next_idx_s;
                        paddr_r  <= reg_addr(next_idx_s);
                        pwdata_r <= reg_data(next_idx_s, op_r, width_r, data_r, noise_r);
                        state_r  <= ST_SETUP;
                    end else begin
                        psel_r   <= 1'b0;
                        pwrite_r <= 1'b0;
                        paddr_r  <= '0;
                        pwdata_r <= '0;
                        cnt_r    <= '0;
                        state_r  <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // A completion on the final timeout cycle still counts as success.
                    if (bus.operation_done) begin
                        rsp_valid_r  <= 1'b1;
                        rsp_data_r   <= bus.data_out;
                        rsp_errors_r <= bus.num_of_errors;
                        rsp_status_r <= STATUS_OK;
                        state_r      <= ST_RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        rsp_valid_r  <= 1'b1;
                        rsp_data_r   <= '0;
                        rsp_errors_r <= 2'd0;
                        rsp_status_r <= STATUS_TIMEOUT;
                        state_r      <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    cnt_r       <= '0;
                    idx_r       <= 2'd0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    pwrite_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.PADDR      = paddr_r;
    assign bus.PWDATA     = pwdata_r;
    assign bus.PSEL       = psel_r;
    assign bus.PENABLE    = penable_r;
    assign bus.PWRITE     = pwrite_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_errors = rsp_errors_r;
    assign bus.rsp_status = rsp_status_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Randomized self-checking bench for ecc_apb_sequencer; expectations come from a
// cycle-numbered transaction model (write list, response cycle, status).
module tb_ecc_apb_sequencer;

    localparam int DW  = 32;
    localparam int AW  = 20;
    localparam int AWD = 32;
    localparam int TMO = 16;
    localparam int FIRST_WAIT = 9;
    localparam int LAST_WAIT  = FIRST_WAIT + TMO - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ecc_apb_sequencer_if #(.DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(AWD)) bus ();

    ecc_apb_sequencer #(
        .DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(AWD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.cmd_valid      = 1'b0;
        bus.cmd_op         = 2'd0;
        bus.cmd_width      = 2'd0;
        bus.cmd_data       = '0;
        bus.cmd_noise      = '0;
        bus.operation_done = 1'b0;
        bus.data_out       = '0;
        bus.num_of_errors  = 2'd0;
    endtask

    // One command from acceptance (cycle 0) to one cycle after its response.
    // done_cyc / spur_cyc are cycle numbers within the transaction, -1 for none.
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [1:0] w,
                           input logic [31:0] d, input logic [31:0] n, input int done_cyc,
                           input logic [31:0] dout, input logic [1:0] nerr, input int spur_cyc);
        logic [19:0] ea [4];
        logic [31:0] ed [4];
        logic        legal;
        int          rsp_cyc;
        logic [35:0] e_rsp;
        logic [5:0]  e_ctl, o_ctl;
        logic        e_psel, e_busy;

        for (int i = 0; i < 50 && bus.cmd_ready !== 1'b1; i++) step();
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL %s ready_wait got=%b exp=1", name, bus.cmd_ready);
        else n_pass++;

        ea[0] = 20'h00008; ed[0] = {30'd0, w};
        ea[1] = 20'h00004; ed[1] = d;
        ea[2] = 20'h0000C; ed[2] = n;
        ea[3] = 20'h00000; ed[3] = {30'd0, op};
        legal = (op != 2'd3) && (w != 2'd3);
        if (!legal) begin
            rsp_cyc = 1;
            e_rsp   = {32'd0, 2'd0, 2'd2};
        end else if (done_cyc >= FIRST_WAIT && done_cyc <= LAST_WAIT) begin
            rsp_cyc = done_cyc + 1;
            e_rsp   = {dout, nerr, 2'd0};
        end else begin
            rsp_cyc = LAST_WAIT + 1;
            e_rsp   = {32'd0, 2'd0, 2'd1};
        end

        bus.cmd_op    = op;
        bus.cmd_width = w;
        bus.cmd_data  = d;
        bus.cmd_noise = n;
        for (int cyc = 0; cyc <= rsp_cyc + 1; cyc++) begin
            bus.cmd_valid      = (cyc == 0);
            bus.operation_done = (cyc == done_cyc) || (cyc == spur_cyc);
            bus.data_out       = bus.operation_done ? dout : $urandom;
            bus.num_of_errors  = bus.operation_done ? nerr : 2'($urandom_range(0, 3));

            e_psel = legal && cyc >= 1 && cyc <= 8;
            e_busy = cyc >= 1 && cyc <= rsp_cyc;
            e_ctl  = {e_psel, e_psel && (cyc % 2 == 0), e_psel, cyc == rsp_cyc, e_busy, !e_busy};
            o_ctl  = {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.busy, bus.cmd_ready};
            n_checks++;
            if (o_ctl !== e_ctl)
                $display("FAIL %s ctrl cyc=%0d got=%b exp=%b (psel,pen,pwr,rv,busy,rdy)",
                         name, cyc, o_ctl, e_ctl);
            else n_pass++;

            if (e_psel) begin
                n_checks++;
                if ({bus.PADDR, bus.PWDATA} !== {ea[(cyc-1)/2], ed[(cyc-1)/2]})
                    $display("FAIL %s apb cyc=%0d got=%h/%h exp=%h/%h", name, cyc,
                             bus.PADDR, bus.PWDATA, ea[(cyc-1)/2], ed[(cyc-1)/2]);
                else n_pass++;
            end

            if (cyc >= rsp_cyc) begin
                n_checks++;
                if ({bus.rsp_data, bus.rsp_errors, bus.rsp_status} !== e_rsp)
                    $display("FAIL %s rsp cyc=%0d got=%h/%0d/%0d exp=%h/%0d/%0d", name, cyc,
                             bus.rsp_data, bus.rsp_errors, bus.rsp_status,
                             e_rsp[35:4], e_rsp[3:2], e_rsp[1:0]);
                else n_pass++;
            end
            step();
        end
        drive_idle();
    endtask

    task automatic test_reset();
        logic [93:0] obs;
        drive_idle();
        rst = 1'b0;
        step();
        step();
        obs = {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.rsp_valid,
               bus.rsp_data, bus.rsp_errors, bus.rsp_status, bus.busy, bus.cmd_ready};
        n_checks++;
        if (obs !== '0) $display("FAIL reset_outputs got=%h exp=0", obs);
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if ({bus.cmd_ready, bus.busy} !== 2'b10)
            $display("FAIL reset_release got=%b exp=10 (rdy,busy)", {bus.cmd_ready, bus.busy});
        else n_pass++;
    endtask

    task automatic test_encode();
        run_cmd("encode", 2'd0, 2'd2, 32'h0000_00A5, 32'h0, 12, 32'h0000_1234, 2'd0, -1);
    endtask

    task automatic test_decode();
        run_cmd("decode", 2'd1, 2'd1, $urandom, $urandom, 10, 32'h0000_005A, 2'd1, -1);
    endtask

    task automatic test_timeout();
        run_cmd("timeout", 2'd2, 2'd0, $urandom, $urandom, -1, 32'hDEAD_BEEF, 2'd2, -1);
        run_cmd("done_at_limit", 2'd0, 2'd2, $urandom, $urandom, LAST_WAIT, 32'hCAFE_0001, 2'd3, -1);
        run_cmd("done_after_limit", 2'd1, 2'd2, $urandom, $urandom, LAST_WAIT + 1, 32'h1, 2'd1, -1);
    endtask

    task automatic test_illegal();
        run_cmd("illegal_op", 2'd3, 2'd1, $urandom, $urandom, -1, 32'h0, 2'd0, -1);
        run_cmd("illegal_width", 2'd0, 2'd3, $urandom, $urandom, -1, 32'h0, 2'd0, -1);
    endtask

    task automatic test_spurious();
        run_cmd("spurious_c4", 2'd1, 2'd2, $urandom, $urandom, 15, 32'h0BAD_F00D, 2'd2, 4);
        run_cmd("spurious_c8", 2'd0, 2'd1, $urandom, $urandom, -1, 32'h0, 2'd0, 8);
    endtask

    task automatic test_mid_reset();
        int seen;
        bus.cmd_op    = 2'd0;
        bus.cmd_width = 2'd2;
        bus.cmd_data  = $urandom;
        bus.cmd_noise = $urandom;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        for (int c = 1; c < 5; c++) step();
        rst = 1'b0;
        step();
        n_checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.busy} !== 5'b0)
            $display("FAIL mid_reset_idle got=%b exp=00000",
                     {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.busy});
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if ({bus.PSEL, bus.cmd_ready, bus.busy} !== 3'b010)
            $display("FAIL mid_reset_release got=%b exp=010 (psel,rdy,busy)",
                     {bus.PSEL, bus.cmd_ready, bus.busy});
        else n_pass++;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            bus.operation_done = (c % 7 == 3);
            if (bus.rsp_valid === 1'b1 || bus.PSEL === 1'b1) seen++;
            step();
        end
        drive_idle();
        n_checks++;
        if (seen !== 0) $display("FAIL mid_reset_quiet got=%0d activity cycles exp=0", seen);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            run_cmd("random", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom,
                    $urandom, ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(9, 28)),
                    $urandom, 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 8)));
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_encode();
        test_decode();
        test_timeout();
        test_illegal();
        test_spurious();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
